// File: rtl/spi_adder_pkg.sv
// Shared types and sizing for the SPI front-end of the BlackBoxAdder.
package spi_adder_pkg;

    typedef enum logic [2:0] {IDLE, RX, CALC, CAP, TX, DONE} state_t;

    localparam int WIDTH_DEFAULT = 32;
    localparam int RX_BITS       = 2 * WIDTH_DEFAULT;
    localparam int TX_BITS       = WIDTH_DEFAULT + 1;
    localparam int CNT_W         = $clog2(RX_BITS + 1);

    function automatic int cnt_width(input int width);
        return $clog2(2 * width + 1);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with rise/fall pulses
// derived from the last two synchronized samples.
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign q_o    = sync_q[STAGES-1];
    assign rise_o = sync_q[STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_adder_frontend.sv
// SPI mode-0 slave: receives two operands, drives the external adder, and
// shifts the captured (WIDTH+1)-bit sum back on miso within the same frame.
module spi_adder_frontend
    import spi_adder_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sclk,
    input  logic             cs_n,
    input  logic             mosi,
    output logic             miso,
    output logic [WIDTH-1:0] adder_in1,
    output logic [WIDTH-1:0] adder_in2,
    input  logic [WIDTH:0]   adder_out,
    output logic [WIDTH:0]   result,
    output logic             result_valid,
    output logic             frame_err,
    output logic             busy
);

    localparam int RX_W = 2 * WIDTH;
    localparam int CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] RX_LAST = CW'(RX_W - 1);
    localparam logic [CW-1:0] TX_LAST = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic sclk_level_unused, sclk_rise, sclk_fall;
    logic cs_hi, cs_rise_unused, cs_fall;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clock(clock), .reset(reset), .d_i(sclk),
        .q_o(sclk_level_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cs (
        .clock(clock), .reset(reset), .d_i(cs_n),
        .q_o(cs_hi), .rise_o(cs_rise_unused), .fall_o(cs_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
        .clock(clock), .reset(reset), .d_i(mosi),
        .q_o(mosi_s), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
    );

    state_t            state_q;
    logic [RX_W-1:0]   rx_q;
    logic [WIDTH:0]    tx_q;
    logic [CW-1:0]     cnt_q;
    logic [WIDTH-1:0]  in1_q, in2_q;
    logic [WIDTH:0]    result_q;
    logic              valid_q, err_q, miso_q;
    logic              abort;

    // Deselect mid-frame takes priority over any sclk edge seen in the same cycle.
    assign abort = cs_hi && (state_q inside {RX, CALC, CAP, TX});

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            rx_q     <= '0;
            tx_q     <= '0;
            cnt_q    <= '0;
            in1_q    <= '0;
            in2_q    <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            miso_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            if (abort) begin
                state_q <= IDLE;
                err_q   <= 1'b1;
                miso_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        miso_q <= 1'b0;
                        if (cs_fall) begin
                            state_q <= RX;
                            cnt_q   <= '0;
                        end
                    end
                    RX: if (sclk_rise) begin
                        rx_q  <= {rx_q[RX_W-2:0], mosi_s};
                        cnt_q <= cnt_q + CNT_ONE;
                        if (cnt_q == RX_LAST) state_q <= CALC;
                    end
                    CALC: begin
                        in1_q   <= rx_q[RX_W-1:WIDTH];
                        in2_q   <= rx_q[WIDTH-1:0];
                        cnt_q   <= '0;
                        state_q <= CAP;
                    end
                    CAP: begin
                        tx_q     <= adder_out;
                        result_q <= adder_out;
                        valid_q  <= 1'b1;
                        miso_q   <= adder_out[WIDTH];
                        state_q  <= TX;
                    end
                    TX: begin
                        // A fall before the first TX rise belongs to the last operand bit.
                        if (sclk_rise) begin
                            cnt_q <= cnt_q + CNT_ONE;
                            if (cnt_q == TX_LAST) begin
                                state_q <= DONE;
                                miso_q  <= 1'b0;
                            end
                        end else if (sclk_fall && cnt_q != '0) begin
                            tx_q   <= {tx_q[WIDTH-1:0], 1'b0};
                            miso_q <= tx_q[WIDTH-1];
                        end
                    end
                    DONE: begin
                        miso_q <= 1'b0;
                        if (cs_hi) state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign miso         = miso_q;
    assign adder_in1    = in1_q;
    assign adder_in2    = in2_q;
    assign result       = result_q;
    assign result_valid = valid_q;
    assign frame_err    = err_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_spi_adder_frontend.sv
// Directed bench for spi_adder_frontend: an SPI master model drives frames and
// a scoreboard checks every result_valid against sums queued at frame start.
module tb_spi_adder_frontend;

    localparam int W    = 32;
    localparam int HALF = 80;

    logic         clock = 1'b0;
    logic         reset, sclk, cs_n, mosi;
    logic         miso;
    logic [W-1:0] adder_in1, adder_in2;
    logic [W:0]   adder_out, result;
    logic         result_valid, frame_err, busy;

    int total = 0;
    int bad = 0;
    int valid_cnt = 0;
    int err_cnt = 0;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W:0]   s;
    } exp_t;
    exp_t sb[$];
    exp_t e_mon;

    // External combinational adder black box.
    assign adder_out = {1'b0, adder_in1} + {1'b0, adder_in2};

    always #5 clock = ~clock;

    spi_adder_frontend #(.WIDTH(W), .SYNC_STAGES(2)) dut (
        .clock(clock), .reset(reset), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .adder_in1(adder_in1), .adder_in2(adder_in2),
        .adder_out(adder_out), .result(result), .result_valid(result_valid),
        .frame_err(frame_err), .busy(busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        if (!reset && frame_err) err_cnt++;
        if (!reset && result_valid) begin
            valid_cnt++;
            check("valid_has_expect", 64'(sb.size() != 0), 64'(1));
            if (sb.size() != 0) begin
                e_mon = sb.pop_front();
                check("sb_result", 64'(result), 64'(e_mon.s));
                check("sb_in1", 64'(adder_in1), 64'(e_mon.a));
                check("sb_in2", 64'(adder_in2), 64'(e_mon.b));
            end
        end
    end

    task automatic spi_bit(input logic b, output logic m);
        mosi = b;
        #(HALF);
        m = miso;
        sclk = 1'b1;
        #(HALF);
        sclk = 1'b0;
    endtask

    task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.a = a;
        e.b = b;
        e.s = {1'b0, a} + {1'b0, b};
        sb.push_back(e);
    endtask

    task automatic send_ops(input logic [W-1:0] a, input logic [W-1:0] b, input int nbits);
        logic [2*W-1:0] v;
        logic m;
        v = {a, b};
        for (int i = 0; i < nbits; i++) spi_bit(v[2*W-1-i], m);
    endtask

    // Sampled result bits land MSB-first at cap[127], cap[126], ...
    task automatic recv(input int n, output logic [127:0] cap);
        logic m;
        cap = '0;
        for (int i = 0; i < n; i++) begin
            spi_bit(1'b0, m);
            cap[127-i] = m;
        end
    endtask

    task automatic full_frame(input logic [W-1:0] a, input logic [W-1:0] b,
                              input int nres, input int gap, output logic [127:0] cap);
        cs_n = 1'b0;
        #(HALF);
        push_exp(a, b);
        send_ops(a, b, 2*W);
        recv(nres, cap);
        #(HALF);
        cs_n = 1'b1;
        #(gap * 10);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_miso"}, 64'(miso), 64'(0));
        check({tag, "_in1"}, 64'(adder_in1), 64'(0));
        check({tag, "_in2"}, 64'(adder_in2), 64'(0));
        check({tag, "_result"}, 64'(result), 64'(0));
        check({tag, "_valid"}, 64'(result_valid), 64'(0));
        check({tag, "_err"}, 64'(frame_err), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
    endtask

    initial begin
        logic [127:0] cap;
        int v0, e0;
        reset = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        #3;
        #30;
        check_all_zero("reset");
        reset = 1'b0;
        #50;

        // Basic add
        v0 = valid_cnt; e0 = err_cnt;
        full_frame(32'h3, 32'h5, 33, 10, cap);
        check("basic_miso", 64'(cap[127:95]), 64'h0_00000008);
        check("basic_in1", 64'(adder_in1), 64'h3);
        check("basic_in2", 64'(adder_in2), 64'h5);
        check("basic_valids", 64'(valid_cnt - v0), 64'(1));
        check("basic_errs", 64'(err_cnt - e0), 64'(0));
        check("basic_busy", 64'(busy), 64'(0));

        // Abort in RX after 40 bits
        v0 = valid_cnt; e0 = err_cnt;
        cs_n = 1'b0;
        #(HALF);
        send_ops(32'hDEADBEEF, 32'hCAFEF00D, 40);
        cs_n = 1'b1;
        #40;
        check("abort_busy", 64'(busy), 64'(0));
        #60;
        check("abort_errs", 64'(err_cnt - e0), 64'(1));
        check("abort_valids", 64'(valid_cnt - v0), 64'(0));
        check("abort_in1", 64'(adder_in1), 64'h3);
        check("abort_in2", 64'(adder_in2), 64'h5);
        check("abort_result", 64'(result), 64'h8);

        // Carry out
        v0 = valid_cnt;
        full_frame(32'hFFFFFFFF, 32'h00000001, 33, 4, cap);
        check("carry_miso", 64'(cap[127:95]), 64'h1_00000000);
        check("carry_first_bit", 64'(cap[127]), 64'(1));
        check("carry_busy", 64'(busy), 64'(0));
        check("carry_valids", 64'(valid_cnt - v0), 64'(1));
        #60;

        // Reset mid-TX after 10 result bits
        cs_n = 1'b0;
        #(HALF);
        push_exp(32'hAAAA0000, 32'h00005555);
        send_ops(32'hAAAA0000, 32'h00005555, 2*W);
        recv(10, cap);
        check("rst_tx_bits", 64'(cap[127:118]), 64'(10'b0101010101));
        reset = 1'b1;
        #10;
        check_all_zero("midreset");
        #10;
        reset = 1'b0;
        v0 = valid_cnt; e0 = err_cnt;
        recv(5, cap);
        check("post_reset_miso", 64'(cap[127:123]), 64'(0));
        #(HALF);
        cs_n = 1'b1;
        #100;
        check("post_reset_valids", 64'(valid_cnt - v0), 64'(0));
        check("post_reset_errs", 64'(err_cnt - e0), 64'(0));
        full_frame(32'h10, 32'h20, 33, 10, cap);
        check("after_reset_miso", 64'(cap[127:95]), 64'h30);
        check("after_reset_result", 64'(result), 64'h30);

        // Over-clocked frame: 110 SCLKs
        v0 = valid_cnt;
        full_frame(32'h80000000, 32'h80000000, 46, 10, cap);
        check("over_miso", 64'(cap[127:95]), 64'h1_00000000);
        check("over_tail_zero", 64'(cap[94:82]), 64'(0));
        check("over_valids", 64'(valid_cnt - v0), 64'(1));

        // Back-to-back frames with 4-clock deselect gap
        v0 = valid_cnt;
        full_frame(32'h12345678, 32'h11111111, 33, 4, cap);
        check("b2b1_miso", 64'(cap[127:95]), 64'h0_23456789);
        check("b2b1_valids", 64'(valid_cnt - v0), 64'(1));
        v0 = valid_cnt;
        full_frame(32'hFFFFFFFF, 32'hFFFFFFFF, 33, 10, cap);
        check("b2b2_miso", 64'(cap[127:95]), 64'h1_FFFFFFFE);
        check("b2b2_valids", 64'(valid_cnt - v0), 64'(1));
        check("b2b2_result", 64'(result), 64'h1_FFFFFFFE);

        #100;
        check("sb_empty", 64'(sb.size()), 64'(0));
        check("valid_total", 64'(valid_cnt), 64'(7));
        check("err_total", 64'(err_cnt), 64'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
